// File: rtl/jtag_tap_core.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register and
// the BYPASS, IDCODE and USER data registers with their TDI->TDO paths.
// The USER register has a parallel capture input and an update output.
//
// state  | meaning
// -------+---------------------------------------------
// TLR    | test-logic-reset, instruction forced to IDCODE
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | parallel load of the selected DR
// SH_DR  | selected DR shifts, tdi into MSB
// EX1_DR | exit-1 DR
// PAU_DR | pause DR, shift registers hold
// EX2_DR | exit-2 DR
// UPD_DR | USER DR content copied to user_dr_out
// SEL_IR | select IR scan
// CAP_IR | ir_sh loaded with ...01
// SH_IR  | ir_sh shifts, tdi into MSB
// EX1_IR | exit-1 IR
// PAU_IR | pause IR, ir_sh holds
// EX2_IR | exit-2 IR
// UPD_IR | ir_sh becomes the active instruction

module jtag_tap_core #(
    parameter int                  IR_WIDTH      = 4,
    parameter logic [31:0]         IDCODE_VAL    = 32'h1234_5ABD,
    parameter int                  USER_DR_WIDTH = 8,
    parameter logic [IR_WIDTH-1:0] INST_IDCODE   = 4'b0001,
    parameter logic [IR_WIDTH-1:0] INST_USER     = 4'b0010
) (
    input  logic                     tck,
    input  logic                     trst_n,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [3:0]               state,
    output logic [IR_WIDTH-1:0]      ir,
    input  logic [USER_DR_WIDTH-1:0] user_dr_in,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic                     user_upd
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    // Capture pattern for the IR: LSB pair reads back as 2'b01.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    tap_state_t               state_q;
    tap_state_t               state_d;
    logic [IR_WIDTH-1:0]      ir_sh;
    logic [IR_WIDTH-1:0]      ir_shift;
    logic [31:0]              id_sh;
    logic [USER_DR_WIDTH-1:0] usr_sh;
    logic [USER_DR_WIDTH-1:0] usr_shift;
    logic                     bypass;
    logic                     sel_idcode;
    logic                     sel_user;

    assign state      = state_q;
    assign tdo_en     = (state_q == SH_DR) || (state_q == SH_IR);
    assign sel_idcode = (ir == INST_IDCODE);
    assign sel_user   = (ir == INST_USER) && !sel_idcode;

    // TAP state register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard 1149.1 next-state decode on tms
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Right-shift helpers; written this way so a 1-bit register still elaborates
    always_comb begin
        ir_shift                      = ir_sh >> 1;
        ir_shift[IR_WIDTH-1]          = tdi;
        usr_shift                     = usr_sh >> 1;
        usr_shift[USER_DR_WIDTH-1]    = tdi;
    end

    // Instruction shift register and active instruction
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_sh <= '0;
            ir    <= INST_IDCODE;
        end else begin
            case (state_q)
                TLR:     ir    <= INST_IDCODE;
                CAP_IR:  ir_sh <= IR_CAPTURE;
                SH_IR:   ir_sh <= ir_shift;
                UPD_IR:  ir    <= ir_sh;
                default: ;
            endcase
        end
    end

    // Data registers: only the one selected by ir captures or shifts
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            bypass <= 1'b0;
            id_sh  <= '0;
            usr_sh <= '0;
        end else if (state_q == CAP_DR) begin
            if (sel_idcode) begin
                id_sh <= IDCODE_VAL;
            end else if (sel_user) begin
                usr_sh <= user_dr_in;
            end else begin
                bypass <= 1'b0;
            end
        end else if (state_q == SH_DR) begin
            if (sel_idcode) begin
                id_sh <= {tdi, id_sh[31:1]};
            end else if (sel_user) begin
                usr_sh <= usr_shift;
            end else begin
                bypass <= tdi;
            end
        end
    end

    // USER update register and its one-cycle strobe
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            user_dr_out <= '0;
            user_upd    <= 1'b0;
        end else begin
            user_upd <= 1'b0;
            if ((state_q == UPD_DR) && sel_user) begin
                user_dr_out <= usr_sh;
                user_upd    <= 1'b1;
            end
        end
    end

    // Serial output mux; driven only in the shift states
    always_comb begin
        tdo = 1'b0;
        if (state_q == SH_IR) begin
            tdo = ir_sh[0];
        end else if (state_q == SH_DR) begin
            if (sel_idcode) begin
                tdo = id_sh[0];
            end else if (sel_user) begin
                tdo = usr_sh[0];
            end else begin
                tdo = bypass;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Scoreboard bench for jtag_tap_core. Stimulus tasks drive tms/tdi on the
// falling edge and queue the values the DUT should present before the next
// rising edge; a monitor drains the queue a little after each falling edge.

module tb_jtag_tap_core;

    localparam logic [31:0] IDCODE_VAL = 32'h1234_5ABD;
    localparam logic [3:0]  OP_IDCODE  = 4'b0001;
    localparam logic [3:0]  OP_USER    = 4'b0010;

    localparam int SIG_STATE = 0;
    localparam int SIG_IR    = 1;
    localparam int SIG_TDO   = 2;
    localparam int SIG_TDOEN = 3;
    localparam int SIG_UDO   = 4;
    localparam int SIG_UPD   = 5;

    localparam logic [31:0] S_TLR = 0, S_RTI = 1, S_SEL_DR = 2, S_SH_DR = 4,
                            S_EX1_DR = 5, S_PAU_DR = 6, S_UPD_DR = 8,
                            S_SH_IR = 11, S_PAU_IR = 13;

    logic       tck;
    logic       trst_n;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] state;
    logic [3:0] ir;
    logic [7:0] user_dr_in;
    logic [7:0] user_dr_out;
    logic       user_upd;

    typedef struct {
        int          sig;
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       checks = 0;
    int       errors = 0;

    jtag_tap_core dut (
        .tck        (tck),
        .trst_n     (trst_n),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .state      (state),
        .ir         (ir),
        .user_dr_in (user_dr_in),
        .user_dr_out(user_dr_out),
        .user_upd   (user_upd)
    );

    // Test clock, rising edges at 5, 15, 25 ...
    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    // Monitor: compares every queued expectation against the live outputs
    initial begin
        sb_item_t    it;
        logic [31:0] act;
        forever begin
            @(negedge tck);
            #3;
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.sig)
                    SIG_STATE: act = {28'd0, state};
                    SIG_IR:    act = {28'd0, ir};
                    SIG_TDO:   act = {31'd0, tdo};
                    SIG_TDOEN: act = {31'd0, tdo_en};
                    SIG_UDO:   act = {24'd0, user_dr_out};
                    default:   act = {31'd0, user_upd};
                endcase
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", it.name, act, it.exp, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic expect_sig(input int sig, input logic [31:0] exp, input string name);
        sb_item_t it;
        it.sig  = sig;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    // Drive tms/tdi for the next rising edge; expectations queued after this
    // refer to the state the DUT is in before that edge.
    task automatic tick(input logic m, input logic d);
        @(negedge tck);
        tms = m;
        tdi = d;
    endtask

    // From RTI: load val into the IR and come back to RTI
    task automatic ir_scan(input logic [3:0] val);
        logic [3:0] cap;
        cap = 4'b0001;
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, val[i]);
            expect_sig(SIG_TDO, {31'd0, cap[i]}, $sformatf("ir_capture_bit%0d", i));
            if (i == 0) expect_sig(SIG_STATE, S_SH_IR, "ir_scan_state");
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    // From RTI: n-bit DR scan, din LSB first, tdo checked against exp
    task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] exp, input string tag);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i]);
            expect_sig(SIG_TDO, {31'd0, exp[i]}, $sformatf("%s_tdo_bit%0d", tag, i));
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        trst_n     = 1'b0;
        tms        = 1'b1;
        tdi        = 1'b0;
        user_dr_in = 8'h00;

        // Reset state
        @(negedge tck);
        expect_sig(SIG_STATE, S_TLR, "rst_state");
        expect_sig(SIG_IR, {28'd0, OP_IDCODE}, "rst_ir");
        expect_sig(SIG_UDO, 32'h0, "rst_user_dr_out");
        expect_sig(SIG_UPD, 32'h0, "rst_user_upd");
        expect_sig(SIG_TDOEN, 32'h0, "rst_tdo_en");
        expect_sig(SIG_TDO, 32'h0, "rst_tdo");
        @(negedge tck);
        trst_n = 1'b1;

        // IDCODE read, 32 bits LSB first
        tick(0, 0);
        expect_sig(SIG_STATE, S_TLR, "tlr_after_release");
        tick(1, 0);
        expect_sig(SIG_STATE, S_RTI, "rti");
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 32; i++) begin
            tick(i == 31, 0);
            expect_sig(SIG_TDO, {31'd0, IDCODE_VAL[i]}, $sformatf("idcode_bit%0d", i));
        end
        expect_sig(SIG_TDOEN, 32'h1, "idcode_tdo_en");
        tick(1, 0);
        expect_sig(SIG_STATE, S_EX1_DR, "idcode_ex1");
        expect_sig(SIG_TDOEN, 32'h0, "ex1_tdo_en");
        tick(0, 0);
        expect_sig(SIG_STATE, S_UPD_DR, "idcode_upd");
        tick(0, 0);
        expect_sig(SIG_STATE, S_RTI, "idcode_back_rti");
        expect_sig(SIG_UPD, 32'h0, "idcode_no_upd");
        expect_sig(SIG_UDO, 32'h0, "idcode_udo_unchanged");

        // All-ones instruction selects BYPASS: one-bit delay
        ir_scan(4'b1111);
        tick(0, 0);
        expect_sig(SIG_IR, 32'hF, "ir_bypass");
        dr_scan(4, 32'b1101, 32'b1010, "bypass");
        tick(0, 0);
        expect_sig(SIG_UPD, 32'h0, "bypass_no_upd");
        expect_sig(SIG_UDO, 32'h0, "bypass_udo_unchanged");

        // USER scan: capture 0x3C, shift in 0xA5
        ir_scan(OP_USER);
        tick(0, 0);
        expect_sig(SIG_IR, {28'd0, OP_USER}, "ir_user");
        user_dr_in = 8'h3C;
        dr_scan(8, 32'hA5, 32'h3C, "user");
        tick(0, 0);
        expect_sig(SIG_UPD, 32'h1, "user_upd_pulse");
        expect_sig(SIG_UDO, 32'hA5, "user_dr_out_a5");
        tick(0, 0);
        expect_sig(SIG_UPD, 32'h0, "user_upd_drop");
        expect_sig(SIG_UDO, 32'hA5, "user_dr_out_hold");

        // USER scan split by a pause; no recapture on resume
        user_dr_in = 8'h81;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, 8'h6E >> i);
            expect_sig(SIG_TDO, (32'h81 >> i) & 32'h1, $sformatf("pause_first_bit%0d", i));
        end
        tick(0, 0);
        user_dr_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick(i == 2, 0);
            expect_sig(SIG_STATE, S_PAU_DR, $sformatf("pause_state%0d", i));
            expect_sig(SIG_TDO, 32'h0, $sformatf("pause_tdo%0d", i));
        end
        tick(0, 0);
        for (int i = 4; i < 8; i++) begin
            tick(i == 7, 8'h6E >> i);
            expect_sig(SIG_TDO, (32'h81 >> i) & 32'h1, $sformatf("pause_second_bit%0d", i));
        end
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        expect_sig(SIG_UPD, 32'h1, "pause_upd_pulse");
        expect_sig(SIG_UDO, 32'h6E, "pause_user_dr_out");

        // Async reset in the middle of a USER shift
        user_dr_in = 8'h5A;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        expect_sig(SIG_STATE, S_SH_DR, "pre_rst_sh_dr");
        expect_sig(SIG_TDO, 32'h0, "pre_rst_tdo_bit0");
        tick(0, 0);
        expect_sig(SIG_TDO, 32'h1, "pre_rst_tdo_bit1");
        #4;
        trst_n = 1'b0;
        tms    = 1'b1;
        #1;
        expect_sig(SIG_STATE, S_TLR, "midshift_rst_state");
        expect_sig(SIG_IR, {28'd0, OP_IDCODE}, "midshift_rst_ir");
        expect_sig(SIG_UDO, 32'h0, "midshift_rst_udo");
        expect_sig(SIG_TDO, 32'h0, "midshift_rst_tdo");
        expect_sig(SIG_TDOEN, 32'h0, "midshift_rst_tdo_en");
        @(negedge tck);
        trst_n = 1'b1;

        // Five tms=1 from PAU_IR with a partially loaded ir_sh
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 1);
        tick(1, 0);
        tick(0, 0);
        tick(1, 0);
        expect_sig(SIG_STATE, S_PAU_IR, "pau_ir_state");
        tick(1, 0);
        tick(1, 0);
        tick(1, 0);
        expect_sig(SIG_IR, 32'h4, "ir_partial_update");
        expect_sig(SIG_STATE, S_SEL_DR, "five_ones_sel_dr");
        tick(1, 0);
        tick(1, 0);
        expect_sig(SIG_STATE, S_TLR, "five_ones_tlr");
        expect_sig(SIG_TDOEN, 32'h0, "five_ones_tdo_en");
        tick(1, 0);
        expect_sig(SIG_IR, {28'd0, OP_IDCODE}, "tlr_ir_idcode");
        expect_sig(SIG_STATE, S_TLR, "tlr_hold");

        repeat (3) @(negedge tck);
        #5;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
